// File: rtl/cpu_writeback.sv
// cpu_writeback: resolves branches, drives kill/redirect, emits stack pop/push commands and counts retired instructions
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-high reset
//   alu__cond_3a              ALU condition flag used by conditional branches
//   alu__out_3a               ALU result, pushed as {3'b000, alu__out_3a}
//   c__branch_3a              00 none, 01 always, 10 if cond, 11 if !cond
//   c__to_push_3a             bit0 push ALU, bit1 push r0, bit2 push r1
//   instruction_3a            instruction word, [31:0] is the branch target
//   pc_3a                     instruction PC
//   r0_3a, r1_3a              saved stack words
//   st__to_pop_3a             number of words to pop
//   kill_4a                   squash younger stages (high KILL_CYCLES cycles after a taken branch)
//   redirect_4a               one-cycle pulse: fetch loads redirect_pc_4a
//   redirect_pc_4a            branch target, held between redirects
//   st__to_pop_4a             pop count (applied before pushes)
//   st__push_cnt_4a           number of valid push slots
//   st__push0_4a..push2_4a    packed push words, unused slots zero
//   retired_4a                count of non-squashed instructions, wraps
module cpu_writeback #(
    parameter int KILL_CYCLES = 2,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu__cond_3a,
    input  logic [31:0]         alu__out_3a,
    input  logic [1:0]          c__branch_3a,
    input  logic [2:0]          c__to_push_3a,
    input  logic [47:0]         instruction_3a,
    input  logic [31:0]         pc_3a,
    input  logic [34:0]         r0_3a,
    input  logic [34:0]         r1_3a,
    input  logic [10:0]         st__to_pop_3a,
    output logic                kill_4a,
    output logic                redirect_4a,
    output logic [31:0]         redirect_pc_4a,
    output logic [10:0]         st__to_pop_4a,
    output logic [1:0]          st__push_cnt_4a,
    output logic [34:0]         st__push0_4a,
    output logic [34:0]         st__push1_4a,
    output logic [34:0]         st__push2_4a,
    output logic [RETIRE_W-1:0] retired_4a
);
    typedef enum logic {IDLE, SHADOW} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        kill_nxt, redirect_nxt, taken;
    logic [31:0] redirect_pc_nxt;
    logic [34:0] alu_word, slot0, slot1, slot2;
    logic [1:0]  push_cnt;
    logic        unused;

    assign unused = ^{instruction_3a[47:32], pc_3a};

    // The instruction in 3a is squashed whenever kill_4a is high this cycle.
    assign taken = !kill_4a && (c__branch_3a == 2'b01 ||
                                (c__branch_3a == 2'b10 && alu__cond_3a) ||
                                (c__branch_3a == 2'b11 && !alu__cond_3a));

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        kill_nxt        = kill_4a;
        redirect_nxt    = 1'b0;
        redirect_pc_nxt = redirect_pc_4a;
        case (state)
            IDLE: if (taken) begin
                state_nxt       = SHADOW;
                cnt_nxt         = 4'(KILL_CYCLES - 1);
                kill_nxt        = 1'b1;
                redirect_nxt    = 1'b1;
                redirect_pc_nxt = instruction_3a[31:0];
            end
            SHADOW: if (cnt != 4'd0) begin
                cnt_nxt = cnt - 4'd1;
            end else begin
                state_nxt = IDLE;
                kill_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            kill_4a        <= 1'b0;
            redirect_4a    <= 1'b0;
            redirect_pc_4a <= 32'd0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            kill_4a        <= kill_nxt;
            redirect_4a    <= redirect_nxt;
            redirect_pc_4a <= redirect_pc_nxt;
        end
    end

    // Pushes are compacted in ALU, r0, r1 order into the lowest free slots.
    always_comb begin
        alu_word = {3'b000, alu__out_3a};
        push_cnt = 2'(c__to_push_3a[0]) + 2'(c__to_push_3a[1]) + 2'(c__to_push_3a[2]);
        slot0    = c__to_push_3a[0] ? alu_word :
                   c__to_push_3a[1] ? r0_3a :
                   c__to_push_3a[2] ? r1_3a : 35'd0;
        slot1    = (c__to_push_3a[0] && c__to_push_3a[1]) ? r0_3a :
                   ((c__to_push_3a[0] ^ c__to_push_3a[1]) && c__to_push_3a[2]) ? r1_3a : 35'd0;
        slot2    = (&c__to_push_3a) ? r1_3a : 35'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st__to_pop_4a   <= 11'd0;
            st__push_cnt_4a <= 2'd0;
            st__push0_4a    <= 35'd0;
            st__push1_4a    <= 35'd0;
            st__push2_4a    <= 35'd0;
            retired_4a      <= '0;
        end else begin
            st__to_pop_4a   <= kill_4a ? 11'd0 : st__to_pop_3a;
            st__push_cnt_4a <= kill_4a ? 2'd0 : push_cnt;
            st__push0_4a    <= kill_4a ? 35'd0 : slot0;
            st__push1_4a    <= kill_4a ? 35'd0 : slot1;
            st__push2_4a    <= kill_4a ? 35'd0 : slot2;
            retired_4a      <= kill_4a ? retired_4a : retired_4a + RETIRE_W'(1);
        end
    end
endmodule

// File: tb/tb_cpu_writeback.sv
// tb_cpu_writeback: randomized and directed checks of cpu_writeback against a behavioural model
module tb_cpu_writeback;
    localparam int KC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cond = 1'b0;
    logic [31:0] alu = '0;
    logic [1:0]  br = '0;
    logic [2:0]  push = '0;
    logic [47:0] instr = '0;
    logic [31:0] pc = '0;
    logic [34:0] r0 = '0, r1 = '0;
    logic [10:0] pop = '0;

    logic        kill, redir;
    logic [31:0] redir_pc;
    logic [10:0] pop_o;
    logic [1:0]  pcnt_o;
    logic [34:0] p0_o, p1_o, p2_o;
    logic [31:0] ret_o;
    logic        kill2, redir2;
    logic [31:0] redir_pc2;
    logic [10:0] pop2;
    logic [1:0]  pcnt2;
    logic [34:0] p02, p12, p22;
    logic [3:0]  ret2;

    cpu_writeback #(.KILL_CYCLES(KC), .RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .alu__cond_3a(cond), .alu__out_3a(alu), .c__branch_3a(br),
        .c__to_push_3a(push), .instruction_3a(instr), .pc_3a(pc), .r0_3a(r0), .r1_3a(r1),
        .st__to_pop_3a(pop), .kill_4a(kill), .redirect_4a(redir), .redirect_pc_4a(redir_pc),
        .st__to_pop_4a(pop_o), .st__push_cnt_4a(pcnt_o), .st__push0_4a(p0_o),
        .st__push1_4a(p1_o), .st__push2_4a(p2_o), .retired_4a(ret_o));

    cpu_writeback #(.KILL_CYCLES(KC), .RETIRE_W(4)) dut_small (
        .clk(clk), .rst(rst), .alu__cond_3a(cond), .alu__out_3a(alu), .c__branch_3a(br),
        .c__to_push_3a(push), .instruction_3a(instr), .pc_3a(pc), .r0_3a(r0), .r1_3a(r1),
        .st__to_pop_3a(pop), .kill_4a(kill2), .redirect_4a(redir2), .redirect_pc_4a(redir_pc2),
        .st__to_pop_4a(pop2), .st__push_cnt_4a(pcnt2), .st__push0_4a(p02),
        .st__push1_4a(p12), .st__push2_4a(p22), .retired_4a(ret2));

    always #5 clk = ~clk;

    // Model: remaining kill cycles, last redirect, packed pushes and a retire count.
    int          m_rem = 0;
    logic        m_redir = 1'b0;
    logic [31:0] m_pc = '0;
    logic [10:0] m_pop = '0;
    logic [1:0]  m_cnt = '0;
    logic [34:0] m_push [3];
    logic [31:0] m_ret = '0;

    always @(posedge clk or posedge rst) begin : model
        logic        sq, tk;
        logic [34:0] w [3];
        logic [34:0] s [3];
        int          n;
        if (rst) begin
            m_rem <= 0; m_redir <= 1'b0; m_pc <= '0; m_pop <= '0; m_cnt <= '0; m_ret <= '0;
            m_push[0] <= '0; m_push[1] <= '0; m_push[2] <= '0;
        end else begin
            sq = m_rem > 0;
            tk = !sq && (br == 2'd1 || (br == 2'd2 && cond) || (br == 2'd3 && !cond));
            w[0] = {3'b000, alu}; w[1] = r0; w[2] = r1;
            s[0] = '0; s[1] = '0; s[2] = '0;
            n = 0;
            if (!sq) for (int i = 0; i < 3; i++) if (push[i]) begin s[n] = w[i]; n++; end
            m_redir <= tk;
            if (tk) m_pc <= instr[31:0];
            m_rem <= sq ? m_rem - 1 : (tk ? KC : 0);
            m_pop <= sq ? 11'd0 : pop;
            m_cnt <= 2'(n);
            m_push[0] <= s[0]; m_push[1] <= s[1]; m_push[2] <= s[2];
            if (!sq) m_ret <= m_ret + 1;
        end
    end

    int pass_cnt = 0, tot_cnt = 0, redir_seen = 0;
    logic en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("kill", 64'(kill), 64'(m_rem != 0));
        chk("redirect", 64'(redir), 64'(m_redir));
        chk("redirect_pc", 64'(redir_pc), 64'(m_pc));
        chk("pop", 64'(pop_o), 64'(m_pop));
        chk("push_cnt", 64'(pcnt_o), 64'(m_cnt));
        chk("push0", 64'(p0_o), 64'(m_push[0]));
        chk("push1", 64'(p1_o), 64'(m_push[1]));
        chk("push2", 64'(p2_o), 64'(m_push[2]));
        chk("retired", 64'(ret_o), 64'(m_ret));
        chk("retired_small", 64'(ret2), 64'(m_ret[3:0]));
    endtask

    task automatic tick();
        @(negedge clk);
        if (en) compare_all();
        if (redir) redir_seen++;
        #1;
    endtask

    task automatic put(input logic [1:0] b, input logic c, input logic [31:0] tgt,
                       input logic [2:0] p, input logic [31:0] a, input logic [34:0] x0,
                       input logic [34:0] x1, input logic [10:0] pp);
        br = b; cond = c; instr = {16'hABCD, tgt}; push = p; alu = a; r0 = x0; r1 = x1; pop = pp;
    endtask

    task automatic idle();
        put(2'd0, 1'b0, 32'd0, 3'b000, 32'd0, 35'd0, 35'd0, 11'd0);
    endtask

    logic [31:0] ret_snap;

    initial begin
        idle();
        tick(); tick();
        rst = 1'b0;
        en = 1'b1;
        chk("reset_kill", 64'(kill), 64'd0);
        chk("reset_retired", 64'(ret_o), 64'd0);
        chk("reset_push_cnt", 64'(pcnt_o), 64'd0);
        chk("reset_redirect", 64'(redir), 64'd0);

        // Unconditional branch with one ALU push, then two squashed instructions.
        put(2'd1, 1'b0, 32'h100, 3'b001, 32'd5, 35'd0, 35'd0, 11'd3);
        tick();
        chk("br_redirect", 64'(redir), 64'd1);
        chk("br_pc", 64'(redir_pc), 64'h100);
        chk("br_push_cnt", 64'(pcnt_o), 64'd1);
        chk("br_push0", 64'(p0_o), 64'd5);
        chk("br_kill", 64'(kill), 64'd1);
        chk("br_pop", 64'(pop_o), 64'd3);
        ret_snap = ret_o;
        put(2'd0, 1'b0, 32'h0, 3'b111, 32'd7, 35'd8, 35'd9, 11'd2);
        tick();
        chk("shadow1_kill", 64'(kill), 64'd1);
        chk("shadow1_push_cnt", 64'(pcnt_o), 64'd0);
        chk("shadow1_redirect", 64'(redir), 64'd0);
        tick();
        chk("shadow2_kill", 64'(kill), 64'd0);
        chk("shadow2_push_cnt", 64'(pcnt_o), 64'd0);
        chk("shadow_retired", 64'(ret_o), 64'(ret_snap));
        tick();
        chk("after_push_cnt", 64'(pcnt_o), 64'd3);
        chk("after_retired", 64'(ret_o), 64'(ret_snap + 32'd1));

        // Conditional branches.
        put(2'd2, 1'b0, 32'h200, 3'b000, 32'd0, 35'd0, 35'd0, 11'd0);
        tick();
        chk("brcond_nt_redirect", 64'(redir), 64'd0);
        chk("brcond_nt_kill", 64'(kill), 64'd0);
        put(2'd3, 1'b0, 32'h300, 3'b000, 32'd0, 35'd0, 35'd0, 11'd0);
        tick();
        chk("brncond_redirect", 64'(redir), 64'd1);
        chk("brncond_pc", 64'(redir_pc), 64'h300);
        idle();
        tick(); tick(); tick();

        // Taken branch in the last shadow cycle is ignored.
        redir_seen = 0;
        put(2'd1, 1'b0, 32'h400, 3'b000, 32'd0, 35'd0, 35'd0, 11'd0);
        tick();
        idle();
        tick();
        put(2'd1, 1'b0, 32'h500, 3'b000, 32'd0, 35'd0, 35'd0, 11'd0);
        tick();
        chk("last_shadow_kill", 64'(kill), 64'd0);
        idle();
        tick();
        chk("last_shadow_kill2", 64'(kill), 64'd0);
        chk("last_shadow_pulses", 64'(redir_seen), 64'd1);
        chk("last_shadow_pc", 64'(redir_pc), 64'h400);

        // Push packing.
        put(2'd0, 1'b0, 32'd0, 3'b110, 32'hFFFF, 35'h7_0000_0001, 35'h2, 11'd0);
        tick();
        chk("pack110_cnt", 64'(pcnt_o), 64'd2);
        chk("pack110_p0", 64'(p0_o), 64'h7_0000_0001);
        chk("pack110_p1", 64'(p1_o), 64'h2);
        chk("pack110_p2", 64'(p2_o), 64'h0);
        put(2'd0, 1'b0, 32'd0, 3'b101, 32'hDEAD_BEEF, 35'h4_0000_0000, 35'h9, 11'd0);
        tick();
        chk("pack101_cnt", 64'(pcnt_o), 64'd2);
        chk("pack101_p0", 64'(p0_o), 64'h0_DEAD_BEEF);
        chk("pack101_p1", 64'(p1_o), 64'h9);
        chk("pack101_p2", 64'(p2_o), 64'h0);

        // Reset mid-shadow aborts it; the next branch gets a full shadow.
        put(2'd1, 1'b0, 32'h600, 3'b000, 32'd0, 35'd0, 35'd0, 11'd0);
        tick();
        chk("pre_reset_kill", 64'(kill), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_kill", 64'(kill), 64'd0);
        chk("async_reset_redirect", 64'(redir), 64'd0);
        idle();
        tick();
        rst = 1'b0;
        put(2'd1, 1'b0, 32'h700, 3'b000, 32'd0, 35'd0, 35'd0, 11'd0);
        tick();
        chk("post_reset_kill", 64'(kill), 64'd1);
        chk("post_reset_redirect", 64'(redir), 64'd1);
        idle();
        tick();
        chk("post_reset_kill_2nd", 64'(kill), 64'd1);
        tick();
        chk("post_reset_kill_end", 64'(kill), 64'd0);

        // Retire counter wrap, using the 4-bit instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        repeat (15) tick();
        chk("wrap_full", 64'(ret2), 64'hF);
        tick();
        chk("wrap_zero", 64'(ret2), 64'h0);
        chk("wrap_wide", 64'(ret_o), 64'd16);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            br    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
            cond  = 1'($urandom);
            push  = 3'($urandom);
            alu   = $urandom;
            instr = 48'({$urandom, $urandom});
            pc    = $urandom;
            r0    = 35'({$urandom, $urandom});
            r1    = 35'({$urandom, $urandom});
            pop   = 11'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
